col_drain_arbiter: RTL and testbench

// - Round-robin drain scheduler for the per-column output controllers of the systolic array.
// - Each column controller presents one buffered result (col_data/col_valid) and pops it on col_read.
// - Block picks one column per cycle, pops one word and registers it onto a single valid/ready stream.
// - Counts words per tile; pulses tile_done after COLS*ROWS words leave the block.

---
 rtl/col_drain_arbiter.sv | 116 +++++++++++
 tb/tb_col_drain_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/col_drain_arbiter.sv
// Round-robin drain of per-column result buffers onto one registered valid/ready stream.
// Optional COL_DRAIN_TAG_EN adds out_col/out_row source tags registered with out_data.
module col_drain_arbiter #(
  parameter int COLS     = 8,
  parameter int ROWS     = 8,
  parameter int OUTWIDTH = 32,
  localparam int CW      = $clog2(COLS),
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COLS-1:0][OUTWIDTH-1:0] col_data,
  input  logic [COLS-1:0]               col_valid,
  output logic [COLS-1:0]               col_read,
  output logic [OUTWIDTH-1:0]           out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          tile_done
`ifdef COL_DRAIN_TAG_EN
  ,
  output logic [CW-1:0]                 out_col,
  output logic [RW-1:0]                 out_row
`endif
);

  localparam int TOTAL = COLS * ROWS;
  localparam int WCW   = $clog2(TOTAL);

  logic [CW-1:0]       rr_ptr_reg;
  logic [WCW-1:0]      word_cnt_reg;
  logic [OUTWIDTH-1:0] out_data_reg;
  logic                out_valid_reg;
  logic                tile_done_reg;
  logic [CW-1:0]       grant_idx;
  logic                grant_found;
  logic                load;
  logic                handshake;
  logic [CW-1:0]       rr_ptr_next;

  // First valid column at or after rr_ptr, wrapping around.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < COLS; i++) begin
      cand = (int'(rr_ptr_reg) + i) % COLS;
      if (!grant_found && col_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = CW'(cand);
      end
    end
  end

  assign load        = (!out_valid_reg || out_ready) && grant_found;
  assign handshake   = out_valid_reg && out_ready;
  assign rr_ptr_next = (grant_idx == CW'(COLS - 1)) ? '0 : grant_idx + CW'(1);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_read
    assign col_read[gi] = load && !rst && (grant_idx == CW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      word_cnt_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      tile_done_reg <= 1'b0;
    end else begin
      tile_done_reg <= 1'b0;
      if (load) begin
        out_data_reg  <= col_data[grant_idx];
        out_valid_reg <= 1'b1;
        rr_ptr_reg    <= rr_ptr_next;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (handshake) begin
        if (word_cnt_reg == WCW'(TOTAL - 1)) begin
          word_cnt_reg  <= '0;
          tile_done_reg <= 1'b1;
        end else begin
          word_cnt_reg <= word_cnt_reg + WCW'(1);
        end
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign tile_done = tile_done_reg;

`ifdef COL_DRAIN_TAG_EN
  logic [RW-1:0] row_cnt_reg [COLS];
  logic [CW-1:0] out_col_reg;
  logic [RW-1:0] out_row_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_col_reg <= '0;
      out_row_reg <= '0;
      for (int c = 0; c < COLS; c++) row_cnt_reg[c] <= '0;
    end else if (load) begin
      out_col_reg <= grant_idx;
      out_row_reg <= row_cnt_reg[grant_idx];
      row_cnt_reg[grant_idx] <= (row_cnt_reg[grant_idx] == RW'(ROWS - 1)) ?
                                '0 : row_cnt_reg[grant_idx] + RW'(1);
    end
  end

  assign out_col = out_col_reg;
  assign out_row = out_row_reg;
`endif

endmodule

// File: tb/tb_col_drain_arbiter.sv
// Directed bench for col_drain_arbiter (8x8, 32-bit): vector table plus multi-cycle sequences.
module tb_col_drain_arbiter;

  localparam int COLS = 8;
  localparam int ROWS = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0][31:0]     col_data = '0;
  logic [7:0]           col_valid = '0;
  logic [7:0]           col_read;
  logic [31:0]          out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 tile_done;
`ifdef COL_DRAIN_TAG_EN
  logic [2:0]           out_col;
  logic [2:0]           out_row;
`endif

  col_drain_arbiter #(.COLS(COLS), .ROWS(ROWS), .OUTWIDTH(32)) dut (
    .clk(clk), .rst(rst), .col_data(col_data), .col_valid(col_valid),
    .col_read(col_read), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .tile_done(tile_done)
`ifdef COL_DRAIN_TAG_EN
    , .out_col(out_col), .out_row(out_row)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  valid;
    logic        rdy;
    logic [7:0]  exp_read;
    logic        exp_ov;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  // Column source model: column c holds words 0x1000+c*16+r, r = 0..ROWS-1
  int          ptr[8];
  logic [7:0]  mask;
  int          hs_cnt;
  bit          td_exp;
  int          td_pulses;
  bit          seen[64];

  function automatic logic [31:0] word(input int c, input int r);
    return 32'h1000 + 32'(c * 16 + r);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 8; c++) ptr[c] = 0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    hs_cnt = 0; td_exp = 1'b0; td_pulses = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; col_valid = '0; col_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Called at posedge+1; drives, checks at posedge+2, returns at next posedge+1.
  task automatic cycle(input logic rdy, input int exp_grant, output int grant);
    logic [31:0] data_b;
    logic        hs;
    logic [31:0] v;
    int          idx;
    out_ready = rdy;
    for (int c = 0; c < 8; c++) begin
      col_valid[c] = mask[c] && (ptr[c] < ROWS);
      col_data[c]  = (ptr[c] < ROWS) ? word(c, ptr[c]) : 32'h0;
    end
    #1;
    chk("tile_done", {31'b0, tile_done}, {31'b0, td_exp});
    if (tile_done) td_pulses++;
    grant = -1;
    for (int c = 0; c < 8; c++) if (col_read[c]) grant = c;
    chk("col_read_legal",
        {31'b0, ($countones(col_read) <= 1) && ((col_read & ~col_valid) == 8'h0)}, 32'd1);
    if (exp_grant >= -1) chk("grant", 32'(grant), 32'(exp_grant));
    if (out_valid && !out_ready) chk("bp_no_read", {24'b0, col_read}, 32'h0);
    hs     = out_valid && out_ready;
    data_b = out_data;
    @(posedge clk);
    #1;
    if (hs) begin
      hs_cnt++;
      v   = data_b - 32'h1000;
      idx = int'(v[6:4]) * 8 + int'(v[2:0]);
      chk("hs_word_unique", {31'b0, (v[31:7] == 0) && !v[3] && !seen[idx]}, 32'd1);
      seen[idx] = 1'b1;
    end
    td_exp = hs && (hs_cnt > 0) && (hs_cnt % 64 == 0);
    if (grant >= 0) begin
      chk("load_valid", {31'b0, out_valid}, 32'd1);
      chk("load_data", out_data, word(grant, ptr[grant]));
`ifdef COL_DRAIN_TAG_EN
      chk("out_col", {29'b0, out_col}, 32'(grant));
      chk("out_row", {29'b0, out_row}, 32'(ptr[grant] % ROWS));
`endif
      ptr[grant]++;
    end
  endtask

  initial begin
    int g;
    int n;
    logic [31:0] held;

    // idle / reset state
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
      chk("idle_col_read", {24'b0, col_read}, 32'd0);
      chk("idle_tile_done", {31'b0, tile_done}, 32'd0);
      @(posedge clk); #1;
    end
    chk("idle_out_data", out_data, 32'd0);

    // vector table: col3 carries 0xA5, others 0x100+c
    vecs[0]  = '{8'h00, 1'b1, 8'h00, 1'b0, 32'h000};
    vecs[1]  = '{8'h08, 1'b1, 8'h08, 1'b0, 32'h000};
    vecs[2]  = '{8'h00, 1'b1, 8'h00, 1'b1, 32'h0A5};
    vecs[3]  = '{8'hFF, 1'b1, 8'h10, 1'b0, 32'h0A5};
    vecs[4]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 32'h104};
    vecs[5]  = '{8'hFF, 1'b1, 8'h20, 1'b1, 32'h104};
    vecs[6]  = '{8'h03, 1'b1, 8'h01, 1'b1, 32'h105};
    vecs[7]  = '{8'h03, 1'b1, 8'h02, 1'b1, 32'h100};
    vecs[8]  = '{8'h81, 1'b1, 8'h80, 1'b1, 32'h101};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 1'b1, 32'h107};
    vecs[10] = '{8'h00, 1'b1, 8'h00, 1'b1, 32'h107};
    vecs[11] = '{8'h00, 1'b1, 8'h00, 1'b0, 32'h107};
    for (int c = 0; c < 8; c++) col_data[c] = 32'h100 + 32'(c);
    col_data[3] = 32'h0A5;
    for (int i = 0; i < 12; i++) begin
      col_valid = vecs[i].valid;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_col_read", i), {24'b0, col_read}, {24'b0, vecs[i].exp_read});
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
`ifdef COL_DRAIN_TAG_EN
      if (i == 2) begin
        chk("vec2_out_col", {29'b0, out_col}, 32'd3);
        chk("vec2_out_row", {29'b0, out_row}, 32'd0);
      end
`endif
      @(posedge clk); #1;
    end

    // round robin, backpressure, full tile with random ready
    do_reset();
    mask = 8'hFF;
    for (int i = 0; i < 9; i++) cycle(1'b1, i % 8, g);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, -1, g);
      chk("bp_data_stable", out_data, held);
    end
    cycle(1'b1, 1, g);
    n = 0;
    while (hs_cnt < 64 && n < 2000) begin
      cycle(1'($urandom_range(0, 1)), -2, g);
      n++;
    end
    chk("tile_hs_reached", {31'b0, hs_cnt == 64}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, -2, g);
    chk("tile_hs_count", 32'(hs_cnt), 32'd64);
    chk("tile_done_pulses", 32'(td_pulses), 32'd1);
    n = 0;
    for (int i = 0; i < 64; i++) if (seen[i]) n++;
    chk("tile_all_words", 32'(n), 32'd64);

    // reset at word 20, then a fresh tile
    do_reset();
    mask = 8'hFF;
    n = 0;
    while (hs_cnt < 20 && n < 200) begin
      cycle(1'b1, -2, g);
      n++;
    end
    chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_col_read", {24'b0, col_read}, 32'd0);
    @(posedge clk); #1;
    chk("reset_col_read_hold", {24'b0, col_read}, 32'd0);
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 0, g);
    n = 0;
    while (hs_cnt < 64 && n < 2000) begin
      cycle(1'($urandom_range(0, 1)), -2, g);
      n++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, -2, g);
    chk("restart_hs_count", 32'(hs_cnt), 32'd64);
    chk("restart_tile_done_pulses", 32'(td_pulses), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
